seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the two-digit seven-segment countdown display of the traffic-light controller. It sits directly downstream of the traffic-light top level. It consumes the tens and units segment patterns, which the 1 Hz controller domain produces and which are not synchronous to the 40 MHz clock. It resynchronises and de-glitches those patterns, then scans them onto one shared 7-bit segment bus with per-digit enables, so a board with common segment lines can be driven.

---
 rtl/seg7_scan_driver_pkg.sv | 19 +
 rtl/seg7_scan_driver_if.sv | 16 +
 rtl/seg7_scan_driver_input_filter.sv | 48 ++++
 rtl/seg7_scan_driver.sv | 113 +++++++++++
 tb/tb_seg7_scan_driver.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constants for the two-digit seven-segment scan driver.
// Optional anti-ghost blanking states are enabled by SCAN_BLANK_EN.
package seg7_scan_pkg;

    typedef enum logic [1:0] {
        BLANK_0 = 2'd0,
        SHOW_0  = 2'd1,
        BLANK_1 = 2'd2,
        SHOW_1  = 2'd3
    } scan_state_e;

    localparam logic [6:0] SEG_OFF   = 7'h00;
    localparam logic [6:0] SEG_ALL   = 7'h7F;

    localparam logic [1:0] DIG_OFF   = 2'b00;
    localparam logic [1:0] DIG_UNITS = 2'b01;
    localparam logic [1:0] DIG_TENS  = 2'b10;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Segment-pattern inputs and multiplexed display outputs of the scan driver.
interface seg7_scan_driver_if;

    logic [6:0] seg1In;
    logic [6:0] seg0In;
    logic       lampTest;
    logic [6:0] segOut;
    logic [1:0] digitEn;

    modport master (output seg1In, output seg0In, output lampTest,
                    input  segOut, input  digitEn);

    modport slave  (input  seg1In, input  seg0In, input  lampTest,
                    output segOut, output digitEn);

endinterface

// File: rtl/seg7_scan_driver_input_filter.sv
// Two-flop synchroniser plus stability filter; shadow only follows a value
// that has been seen unchanged for STABLE_CYCLES consecutive samples.
module seg7_input_filter #(
    parameter int unsigned WIDTH         = 14,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned    CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

    logic [WIDTH-1:0] s1_q, s2_q, prev_q, shadow_q;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (s2_q != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            s1_q   <= data_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            cnt_q  <= cnt_d;
            if (cnt_q == CNT_MAX) begin
                shadow_q <= prev_q;
            end
        end
    end

    assign data_o = shadow_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit seven-segment scan driver with registered, polarity-selectable outputs.
// Define SCAN_BLANK_EN to insert anti-ghost blank slots before each digit.
module seg7_scan_driver
    import seg7_scan_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 40000000,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned BLANK_CYCLES   = 400,
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    seg7_scan_driver_if.slave   disp_if
);

    localparam int unsigned   DIGIT_TICKS = CLK_HZ / SCAN_HZ;
    localparam int unsigned   CW          = $clog2(DIGIT_TICKS);
    localparam logic [6:0]    SEG_INV     = SEG_ACTIVE_LOW ? SEG_ALL : SEG_OFF;
    localparam logic [1:0]    DIG_INV     = DIG_ACTIVE_LOW ? 2'b11 : DIG_OFF;

`ifdef SCAN_BLANK_EN
    localparam scan_state_e   FRAME_START = BLANK_0;
    localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST   = CW'(DIGIT_TICKS - BLANK_CYCLES - 1);
`else
    localparam scan_state_e   FRAME_START = SHOW_0;
    localparam logic [CW-1:0] SHOW_LAST   = CW'(DIGIT_TICKS - 1);
`endif

    if (DIGIT_TICKS < 4 || BLANK_CYCLES >= DIGIT_TICKS || STABLE_CYCLES < 1) begin : g_bad_cfg
        $error("seg7_scan_driver: invalid scan/blank/stable parameters");
    end

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [13:0]   shadow;
    logic [6:0]    disp_hi_q, disp_lo_q;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    dig_q, dig_d;
    logic          load_frame;

    seg7_input_filter #(
        .WIDTH         (14),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk_i  (clock),
        .rst_i  (reset),
        .data_i ({disp_if.seg1In, disp_if.seg0In}),
        .data_o (shadow)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
`ifdef SCAN_BLANK_EN
            BLANK_0: if (cnt_q == BLANK_LAST) state_d = SHOW_0;
            SHOW_0:  if (cnt_q == SHOW_LAST)  state_d = BLANK_1;
            BLANK_1: if (cnt_q == BLANK_LAST) state_d = SHOW_1;
            SHOW_1:  if (cnt_q == SHOW_LAST)  state_d = BLANK_0;
`else
            SHOW_0:  if (cnt_q == SHOW_LAST)  state_d = SHOW_1;
            SHOW_1:  if (cnt_q == SHOW_LAST)  state_d = SHOW_0;
`endif
            default: state_d = FRAME_START;
        endcase

        cnt_d      = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        // Reset parks the FSM in FRAME_START without a transition, so no reload then.
        load_frame = (state_d == FRAME_START) && (state_q != FRAME_START);

        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
        case (state_q)
            SHOW_0: begin
                dig_d = DIG_UNITS;
                seg_d = disp_if.lampTest ? SEG_ALL : disp_lo_q;
            end
            SHOW_1: begin
                dig_d = DIG_TENS;
                seg_d = disp_if.lampTest ? SEG_ALL : disp_hi_q;
            end
            default: ;
        endcase
        seg_d = seg_d ^ SEG_INV;
        dig_d = dig_d ^ DIG_INV;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FRAME_START;
            cnt_q     <= '0;
            disp_hi_q <= '0;
            disp_lo_q <= '0;
            seg_q     <= SEG_INV;
            dig_q     <= DIG_INV;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            if (load_frame) begin
                disp_hi_q <= shadow[13:7];
                disp_lo_q <= shadow[6:0];
            end
        end
    end

    assign disp_if.segOut  = seg_q;
    assign disp_if.digitEn = dig_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: active-high and active-low instances
// driven in lockstep; follows SCAN_BLANK_EN for the expected scan pattern.
module tb_seg7_scan_driver;

    logic       clk;
    logic       rst;
    logic [6:0] seg1, seg0;
    logic       lamp;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [6:0] lo_tab [11];
    logic [6:0] hi_tab [11];

    seg7_scan_driver_if if_p ();
    seg7_scan_driver_if if_n ();

    assign if_p.seg1In   = seg1;
    assign if_p.seg0In   = seg0;
    assign if_p.lampTest = lamp;
    assign if_n.seg1In   = seg1;
    assign if_n.seg0In   = seg0;
    assign if_n.lampTest = lamp;

    seg7_scan_driver #(
        .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2), .STABLE_CYCLES(3),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .clock(clk), .reset(rst), .disp_if(if_p.slave)
    );

    seg7_scan_driver #(
        .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2), .STABLE_CYCLES(3),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_n (
        .clock(clk), .reset(rst), .disp_if(if_n.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for output window k after reset release (k counts from 0).
    task automatic check_window(input int k, input logic [6:0] lo, input logic [6:0] hi,
                                input bit lamp_on, input string pfx);
        int         ph;
        logic [6:0] es;
        logic [1:0] ed;
        ph = k % 20;
        es = 7'h00;
        ed = 2'b00;
`ifdef SCAN_BLANK_EN
        if (ph >= 2 && ph < 10) begin
            ed = 2'b01; es = lamp_on ? 7'h7F : lo;
        end else if (ph >= 12) begin
            ed = 2'b10; es = lamp_on ? 7'h7F : hi;
        end
`else
        if (ph < 10) begin
            ed = 2'b01; es = lamp_on ? 7'h7F : lo;
        end else begin
            ed = 2'b10; es = lamp_on ? 7'h7F : hi;
        end
`endif
        check($sformatf("%s seg k=%0d", pfx, k), {1'b0, if_p.segOut}, {1'b0, es});
        check($sformatf("%s dig k=%0d", pfx, k), {6'b0, if_p.digitEn}, {6'b0, ed});
        check($sformatf("%s seg_n k=%0d", pfx, k), {1'b0, if_n.segOut}, {1'b0, es ^ 7'h7F});
        check($sformatf("%s dig_n k=%0d", pfx, k), {6'b0, if_n.digitEn}, {6'b0, ed ^ 2'b11});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk  = 1'b0;
        rst  = 1'b1;
        seg1 = 7'h3F;
        seg0 = 7'h06;
        lamp = 1'b0;

        lo_tab[0] = 7'h00; hi_tab[0] = 7'h00;
        for (int f = 1; f <= 5; f++) begin
            lo_tab[f] = 7'h4F; hi_tab[f] = 7'h5B;
        end
        lo_tab[6]  = 7'h7F; hi_tab[6]  = 7'h5B;
        lo_tab[7]  = 7'h4F; hi_tab[7]  = 7'h5B;
        lo_tab[8]  = 7'h06; hi_tab[8]  = 7'h66;
        lo_tab[9]  = 7'h06; hi_tab[9]  = 7'h66;
        lo_tab[10] = 7'h06; hi_tab[10] = 7'h66;

        for (int i = 0; i < 5; i++) begin
            step();
            check("rst seg",   {1'b0, if_p.segOut},  8'h00);
            check("rst dig",   {6'b0, if_p.digitEn}, 8'h00);
            check("rst seg_n", {1'b0, if_n.segOut},  8'h7F);
            check("rst dig_n", {6'b0, if_n.digitEn}, 8'h03);
        end

        seg1 = 7'h5B;
        seg0 = 7'h4F;
        step();
        rst = 1'b0;

        for (int k = 0; k < 215; k++) begin
            step();
            check_window(k, lo_tab[k / 20], hi_tab[k / 20], (k >= 180 && k < 200), "scan");
            case (k)
                71:  seg0 = 7'h7F;
                74:  seg0 = 7'h4F;
                109: seg0 = 7'h7F;
                114: seg0 = 7'h4F;
                140: seg1 = 7'h66;
                150: seg0 = 7'h06;
                179: lamp = 1'b1;
                199: lamp = 1'b0;
                214: rst  = 1'b1;
                default: ;
            endcase
        end

        step();
        check("midrst seg",   {1'b0, if_p.segOut},  8'h00);
        check("midrst dig",   {6'b0, if_p.digitEn}, 8'h00);
        check("midrst seg_n", {1'b0, if_n.segOut},  8'h7F);
        check("midrst dig_n", {6'b0, if_n.digitEn}, 8'h03);
        rst = 1'b0;

        for (int k = 0; k < 40; k++) begin
            step();
            if (k < 20) check_window(k, 7'h00, 7'h00, 1'b0, "restart");
            else        check_window(k, 7'h06, 7'h66, 1'b0, "restart");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
